// File: rtl/zrb_uart_tx_fifo_param.sv
// rtl/zrb_uart_tx_fifo_param.sv - parametrised UART transmitter with internal baud divider and one-word holding buffer
module zrb_uart_tx_fifo_param #(
    parameter int CLK_FREQ  = 25000000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int DIVISOR = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int CW      = (DIVISOR < 2) ? 1 : $clog2(DIVISOR);

    localparam logic [CW-1:0] BAUD_LAST = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] BAUD_PRE  = CW'(DIVISOR - 2);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY == 1);

    if (DIVISOR < 2) begin : g_bad_divisor
        $error("zrb_uart_tx_fifo_param: DIVISOR must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("zrb_uart_tx_fifo_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("zrb_uart_tx_fifo_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("zrb_uart_tx_fifo_param: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t               state;
    logic [CW-1:0]        baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic [DATA_BITS-1:0] buf_data;
    logic                 buf_valid;

    logic                 baud_tick;
    logic                 last_stop;
    logic                 xfer;
    logic                 load_from_buf;
    logic                 load_direct;
    logic                 load;
    logic [DATA_BITS-1:0] load_word;

    assign in_ready      = ~buf_valid;
    assign baud_tick     = (baud_cnt == BAUD_LAST);
    assign last_stop     = (state == ST_STOP) && baud_tick && (bit_cnt == STOP_LAST);
    assign xfer          = in_valid && !buf_valid;
    // The buffered word always wins the shifter; a fresh word only goes direct when the buffer is empty.
    assign load_from_buf = last_stop && buf_valid;
    assign load_direct   = xfer && ((state == ST_IDLE) || (last_stop && !buf_valid));
    assign load          = load_from_buf || load_direct;
    assign load_word     = load_from_buf ? buf_data : in_data;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            buf_valid  <= 1'b0;
            buf_data   <= '0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
        end else begin
            // Registered one clock early so the pulse lands on the final stop clock itself.
            frame_done <= (state == ST_STOP) && (baud_cnt == BAUD_PRE) && (bit_cnt == STOP_LAST);

            if (load_from_buf) begin
                buf_valid <= 1'b0;
            end else if (xfer && !load_direct) begin
                buf_data  <= in_data;
                buf_valid <= 1'b1;
            end

            if (load) begin
                state    <= ST_START;
                tx       <= 1'b0;
                busy     <= 1'b1;
                baud_cnt <= '0;
                bit_cnt  <= '0;
                shreg    <= load_word;
                par_bit  <= (^load_word) ^ PAR_ODD;
            end else begin
                if (state != ST_IDLE) begin
                    baud_cnt <= baud_tick ? '0 : baud_cnt + 1'b1;
                end
                case (state)
                    ST_IDLE: begin
                        tx   <= 1'b1;
                        busy <= 1'b0;
                    end
                    ST_START: begin
                        if (baud_tick) begin
                            state   <= ST_DATA;
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        if (baud_tick) begin
                            if (bit_cnt == DATA_LAST) begin
                                bit_cnt <= '0;
                                if (PARITY != 0) begin
                                    state <= ST_PARITY;
                                    tx    <= par_bit;
                                end else begin
                                    state <= ST_STOP;
                                    tx    <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                tx      <= shreg[0];
                                shreg   <= shreg >> 1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (baud_tick) begin
                            state   <= ST_STOP;
                            tx      <= 1'b1;
                            bit_cnt <= '0;
                        end
                    end
                    ST_STOP: begin
                        if (baud_tick) begin
                            if (bit_cnt == STOP_LAST) begin
                                state    <= ST_IDLE;
                                tx       <= 1'b1;
                                busy     <= 1'b0;
                                baud_cnt <= '0;
                                bit_cnt  <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_zrb_uart_tx_fifo_param.sv
// tb/tb_zrb_uart_tx_fifo_param.sv - directed self-checking bench for zrb_uart_tx_fifo_param
module tb_zrb_uart_tx_fifo_param;

    localparam int DIV = 10;

    logic       clk;
    logic [4:0] rstn;
    logic [4:0] vld;
    logic [8:0] dat [5];
    logic [4:0] tx_w;
    logic [4:0] busy_w;
    logic [4:0] done_w;
    logic [4:0] rdy_w;

    int n_checks;
    int n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0: 8N1, 1: 8E1, 2: 8O1, 3: 5N2 (all DIVISOR 10), 4: 25 MHz / 9600 8N1
    zrb_uart_tx_fifo_param #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .reset_n(rstn[0]), .in_data(dat[0][7:0]), .in_valid(vld[0]), .in_ready(rdy_w[0]),
        .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(done_w[0]));
    zrb_uart_tx_fifo_param #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .reset_n(rstn[1]), .in_data(dat[1][7:0]), .in_valid(vld[1]), .in_ready(rdy_w[1]),
        .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(done_w[1]));
    zrb_uart_tx_fifo_param #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .reset_n(rstn[2]), .in_data(dat[2][7:0]), .in_valid(vld[2]), .in_ready(rdy_w[2]),
        .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(done_w[2]));
    zrb_uart_tx_fifo_param #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u_5n2 (
        .clk(clk), .reset_n(rstn[3]), .in_data(dat[3][4:0]), .in_valid(vld[3]), .in_ready(rdy_w[3]),
        .tx(tx_w[3]), .busy(busy_w[3]), .frame_done(done_w[3]));
    zrb_uart_tx_fifo_param #(.CLK_FREQ(25000000), .BAUD(9600), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_rnd (
        .clk(clk), .reset_n(rstn[4]), .in_data(dat[4][7:0]), .in_valid(vld[4]), .in_ready(rdy_w[4]),
        .tx(tx_w[4]), .busy(busy_w[4]), .frame_done(done_w[4]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents w for one cycle (cycle 0); returns in cycle 1 with in_data scrambled.
    task automatic send_word(input int idx, input logic [8:0] w);
        vld[idx] = 1'b1;
        dat[idx] = w;
        tick();
        vld[idx] = 1'b0;
        dat[idx] = 9'h1FF;
    endtask

    // bits[0] is the start bit; each entry lasts DIV cycles starting at the current cycle.
    task automatic expect_frame(input int idx, input logic [31:0] bits, input int nbits,
                                input int inj_c, input logic [8:0] inj_w, input string tag);
        logic [31:0] obs;
        int tx_err, busy_err, done_err, rdy_err;
        obs = '0;
        tx_err = 0; busy_err = 0; done_err = 0; rdy_err = 0;
        for (int c = 1; c <= nbits * DIV; c++) begin
            int b, k;
            b = (c - 1) / DIV;
            k = (c - 1) % DIV;
            if (k == DIV / 2) obs[b] = tx_w[idx];
            if (tx_w[idx] !== bits[b]) tx_err++;
            if (busy_w[idx] !== 1'b1) busy_err++;
            if (done_w[idx] !== ((b == nbits - 1) && (k == DIV - 1))) done_err++;
            if (rdy_w[idx] !== !(inj_c > 0 && c > inj_c)) rdy_err++;
            if (c == inj_c) begin
                vld[idx] = 1'b1;
                dat[idx] = inj_w;
            end
            tick();
            vld[idx] = 1'b0;
        end
        check({tag, " bits"}, obs, bits);
        check({tag, " tx bad cycles"}, tx_err, 0);
        check({tag, " busy bad cycles"}, busy_err, 0);
        check({tag, " frame_done bad cycles"}, done_err, 0);
        check({tag, " in_ready bad cycles"}, rdy_err, 0);
    endtask

    task automatic expect_idle(input int idx, input string tag);
        check({tag, " idle tx"}, tx_w[idx], 1'b1);
        check({tag, " idle busy"}, busy_w[idx], 1'b0);
        check({tag, " idle frame_done"}, done_w[idx], 1'b0);
        check({tag, " idle in_ready"}, rdy_w[idx], 1'b1);
    endtask

    initial begin
        int n, lows, highs;
        n_checks = 0;
        n_pass   = 0;
        rstn = '0;
        vld  = '0;
        for (int i = 0; i < 5; i++) dat[i] = '0;
        tick(); tick(); tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("reset in_ready %0d", i), rdy_w[i], 1'b1);
            check($sformatf("reset tx %0d", i), tx_w[i], 1'b1);
        end
        rstn = '1;
        tick();
        for (int i = 0; i < 5; i++) expect_idle(i, $sformatf("post-reset %0d", i));

        // 8N1 0x55
        send_word(0, 9'h055);
        expect_frame(0, 32'h2AA, 10, 0, 9'h0, "8n1 0x55");
        expect_idle(0, "8n1 0x55");

        // Parity frames, 110 cycles each
        send_word(1, 9'h007);
        expect_frame(1, 32'h60E, 11, 0, 9'h0, "8e1 0x07");
        expect_idle(1, "8e1 0x07");
        send_word(2, 9'h007);
        expect_frame(2, 32'h40E, 11, 0, 9'h0, "8o1 0x07");
        expect_idle(2, "8o1 0x07");
        send_word(2, 9'h000);
        expect_frame(2, 32'h600, 11, 0, 9'h0, "8o1 0x00");
        expect_idle(2, "8o1 0x00");

        // Back-to-back: 0xA5 at cycle 0, 0x3C buffered at cycle 5
        send_word(0, 9'h0A5);
        expect_frame(0, 32'h34A, 10, 5, 9'h03C, "b2b first");
        expect_frame(0, 32'h278, 10, 0, 9'h0, "b2b second");
        expect_idle(0, "b2b");

        // 5 data bits, 2 stop bits, 80 cycles
        send_word(3, 9'h01F);
        expect_frame(3, 32'h0FE, 8, 0, 9'h0, "5n2 0x1F");
        expect_idle(3, "5n2 0x1F");

        // Reset mid-frame with a buffered word
        send_word(0, 9'h05A);
        repeat (4) tick();
        vld[0] = 1'b1;
        dat[0] = 9'h033;
        tick();
        vld[0] = 1'b0;
        check("rst buffered in_ready", rdy_w[0], 1'b0);
        repeat (39) tick();
        check("rst pre busy", busy_w[0], 1'b1);
        rstn[0] = 1'b0;
        tick();
        check("rst tx", tx_w[0], 1'b1);
        check("rst busy", busy_w[0], 1'b0);
        check("rst in_ready", rdy_w[0], 1'b1);
        vld[0] = 1'b1;
        dat[0] = 9'h000;
        tick();
        vld[0] = 1'b0;
        rstn[0] = 1'b1;
        lows = 0;
        highs = 0;
        for (int c = 0; c < 300; c++) begin
            if (tx_w[0] !== 1'b1) lows++;
            if (busy_w[0] !== 1'b0) highs++;
            tick();
        end
        check("rst no replay tx low cycles", lows, 0);
        check("rst no replay busy cycles", highs, 0);

        // Divisor rounding: 25e6 / 9600 -> 2604 clocks per bit
        send_word(4, 9'h001);
        n = 0;
        while (tx_w[4] === 1'b0 && n < 5000) begin
            n++;
            tick();
        end
        check("rnd start bit length", n, 2604);
        n = 0;
        while (tx_w[4] === 1'b1 && n < 5000) begin
            n++;
            tick();
        end
        check("rnd d0 length", n, 2604);
        rstn[4] = 1'b0;
        tick();
        rstn[4] = 1'b1;
        tick();
        expect_idle(4, "rnd after reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
